// File: rtl/mips_pkg.sv
// Shared constants for the MIPS register file slice.
// Optional write-through bypass: REGFILE_BYPASS_EN.
package mips_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_CNT_W  = 2;
  localparam int NUM_REGS   = 2**DEF_ADDR_W;
  localparam logic [DEF_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register in-flight write counters, sticky error flag, hazard lookups.
// REGFILE_BYPASS_EN: last pending write landing this cycle is not a hazard.
module regfile_scoreboard
  import mips_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_add,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_add,
  input  logic [ADDR_W-1:0] rs_add,
  input  logic [ADDR_W-1:0] rt_add,
  output logic              hz_rs,
  output logic              hz_rt,
  output logic              sb_err
);

  localparam int N = 2**ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];
  logic             err_q, err_d;
  logic             inc, dec;

  always_comb begin
    err_d = err_q;
    inc   = 1'b0;
    dec   = 1'b0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      inc = issue_en && (issue_add == ADDR_W'(i)) && (i != 0);
      dec = wb_en && (wb_add == ADDR_W'(i)) && (i != 0);
      // issue and retire on the same register cancel out
      if (inc && !dec) begin
        if (cnt_q[i] == CNT_MAX) err_d = 1'b1;
        else cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (dec && !inc) begin
        if (cnt_q[i] == '0) err_d = 1'b1;
        else cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  function automatic logic hz(input logic [ADDR_W-1:0] a);
    logic h;
    h = (a != '0) && (cnt_q[a] != '0);
`ifdef REGFILE_BYPASS_EN
    if (wb_en && (wb_add == a) && (cnt_q[a] == CNT_W'(1)))
      h = 1'b0;
`endif
    return h;
  endfunction

  assign hz_rs  = hz(rs_add);
  assign hz_rt  = hz(rt_add);
  assign sb_err = err_q;

endmodule

// File: rtl/mips_regfile.sv
// Architectural register file: storage, two read ports, decode stall.
// REGFILE_BYPASS_EN enables write-through of the write-back data.
module mips_regfile
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              wb_write_reg,
  input  logic [ADDR_W-1:0] wb_add,
  input  logic [ADDR_W-1:0] rs_add,
  input  logic [ADDR_W-1:0] rt_add,
  input  logic              rs_used,
  input  logic              rt_used,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_add,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              stall,
  output logic              sb_err
);

  localparam int N = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] R0 = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs_q [N];
  logic              hz_rs, hz_rt;
  logic              issue_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) regs_q[i] <= '0;
    end else if (wb_write_reg && (wb_add != R0)) begin
      regs_q[wb_add] <= wb_data;
    end
  end

  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = regs_q[a];
`ifdef REGFILE_BYPASS_EN
    if (wb_write_reg && (wb_add == a)) v = wb_data;
`endif
    if (a == R0) v = '0;
    return v;
  endfunction

  assign rs_data = reset ? '0 : rd(rs_add);
  assign rt_data = reset ? '0 : rd(rt_add);

  assign stall = !reset &&
                 ((rs_used && hz_rs) || (rt_used && hz_rt));

  // a stalled instruction never reaches the scoreboard
  assign issue_en = issue_valid && !stall;

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .issue_en  (issue_en),
    .issue_add (issue_add),
    .wb_en     (wb_write_reg),
    .wb_add    (wb_add),
    .rs_add    (rs_add),
    .rt_add    (rt_add),
    .hz_rs     (hz_rs),
    .hz_rt     (hz_rt),
    .sb_err    (sb_err)
  );

endmodule

// File: tb/tb_mips_regfile.sv
// Randomized bench for mips_regfile against an array/integer model.
// Honours REGFILE_BYPASS_EN the same way as the design.
module tb_mips_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] wb_data;
  logic        wb_write_reg;
  logic [4:0]  wb_add;
  logic [4:0]  rs_add, rt_add;
  logic        rs_used, rt_used;
  logic        issue_valid;
  logic [4:0]  issue_add;
  logic [31:0] rs_data, rt_data;
  logic        stall, sb_err;

  int checks   = 0;
  int failures = 0;

  int          m_cnt [32];
  logic [31:0] m_reg [32];
  bit          m_err;
  bit          m_valid = 1'b0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  mips_regfile dut (
    .clk          (clk),
    .reset        (reset),
    .wb_data      (wb_data),
    .wb_write_reg (wb_write_reg),
    .wb_add       (wb_add),
    .rs_add       (rs_add),
    .rt_add       (rt_add),
    .rs_used      (rs_used),
    .rt_used      (rt_used),
    .issue_valid  (issue_valid),
    .issue_add    (issue_add),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .stall        (stall),
    .sb_err       (sb_err)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] m_rd(logic [4:0] a);
    if (reset || a == 5'd0) return 32'd0;
    if (BYP && wb_write_reg && wb_add == a) return wb_data;
    return m_reg[a];
  endfunction

  function automatic bit m_hz(logic [4:0] a);
    if (a == 5'd0 || m_cnt[a] == 0) return 1'b0;
    if (BYP && m_cnt[a] == 1 && wb_write_reg && wb_add == a)
      return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_stall();
    if (reset) return 1'b0;
    return (rs_used && m_hz(rs_add)) || (rt_used && m_hz(rt_add));
  endfunction

  task automatic idle();
    reset        = 1'b0;
    wb_data      = 32'd0;
    wb_write_reg = 1'b0;
    wb_add       = 5'd0;
    rs_add       = 5'd0;
    rt_add       = 5'd0;
    rs_used      = 1'b0;
    rt_used      = 1'b0;
    issue_valid  = 1'b0;
    issue_add    = 5'd0;
  endtask

  // compare the DUT against the model for the current inputs
  task automatic settle();
    #1;
    chk("rs_data", rs_data, m_rd(rs_add));
    chk("rt_data", rt_data, m_rd(rt_add));
    chk("stall", 32'(stall), 32'(m_stall()));
    if (m_valid) chk("sb_err", 32'(sb_err), 32'(m_err));
  endtask

  task automatic adv();
    bit          st, r, wbe, iv, inc, dec;
    logic [4:0]  wa, ia;
    logic [31:0] wd;
    st  = m_stall();
    r   = reset;
    wbe = wb_write_reg;
    wa  = wb_add;
    wd  = wb_data;
    iv  = issue_valid;
    ia  = issue_add;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) begin
        m_cnt[i] = 0;
        m_reg[i] = 32'd0;
      end
      m_err   = 1'b0;
      m_valid = 1'b1;
    end else begin
      if (wbe && wa != 5'd0) m_reg[wa] = wd;
      inc = iv && !st && ia != 5'd0;
      dec = wbe && wa != 5'd0;
      if (!(inc && dec && ia == wa)) begin
        if (inc) begin
          if (m_cnt[ia] == 3) m_err = 1'b1;
          else m_cnt[ia]++;
        end
        if (dec) begin
          if (m_cnt[wa] == 0) m_err = 1'b1;
          else m_cnt[wa]--;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic tick();
    settle();
    adv();
  endtask

  initial begin
    idle();
    // reset with a write-back to r5 pending on the bus
    reset = 1'b1; wb_write_reg = 1'b1; wb_add = 5'd5; wb_data = 32'h55;
    tick(); tick();
    idle(); rs_add = 5'd5;
    settle();
    chk("rst_r5", rs_data, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_err", 32'(sb_err), 32'd0);
    adv();

    idle(); issue_valid = 1'b1; issue_add = 5'd7; tick();
    idle(); wb_write_reg = 1'b1; wb_add = 5'd7;
    wb_data = 32'hDEADBEEF; tick();
    idle(); rs_add = 5'd7;
    settle();
    chk("r7_read", rs_data, 32'hDEADBEEF);
    chk("r7_err", 32'(sb_err), 32'd0);
    adv();

    idle(); wb_write_reg = 1'b1; wb_add = 5'd0; wb_data = 32'h1234; tick();
    idle(); rs_add = 5'd0; rt_add = 5'd0;
    settle();
    chk("r0_read", rt_data, 32'd0);
    adv();

    // RAW hazard on r3
    idle(); issue_valid = 1'b1; issue_add = 5'd3; tick();
    idle(); rs_used = 1'b1; rs_add = 5'd3;
    settle();
    chk("hz_stall", 32'(stall), 32'd1);
    adv();
    idle(); rs_used = 1'b1; rs_add = 5'd3;
    wb_write_reg = 1'b1; wb_add = 5'd3; wb_data = 32'hAAAA;
    settle();
`ifdef REGFILE_BYPASS_EN
    chk("wb_stall", 32'(stall), 32'd0);
    chk("wb_bypass", rs_data, 32'hAAAA);
`else
    chk("wb_stall", 32'(stall), 32'd1);
    chk("wb_old", rs_data, 32'd0);
`endif
    adv();
    idle(); rs_used = 1'b1; rs_add = 5'd3;
    settle();
    chk("post_stall", 32'(stall), 32'd0);
    chk("post_r3", rs_data, 32'hAAAA);
    adv();

    // same-cycle issue and write-back to r9
    idle(); issue_valid = 1'b1; issue_add = 5'd9; tick();
    idle(); issue_valid = 1'b1; issue_add = 5'd9;
    wb_write_reg = 1'b1; wb_add = 5'd9; wb_data = 32'h99; tick();
    idle(); rs_used = 1'b1; rs_add = 5'd9;
    settle();
    chk("r9_stall", 32'(stall), 32'd1);
    adv();
    idle(); wb_write_reg = 1'b1; wb_add = 5'd9; tick();

    // overflow on r4
    idle(); reset = 1'b1; tick();
    for (int k = 0; k < 4; k++) begin
      idle(); issue_valid = 1'b1; issue_add = 5'd4; tick();
    end
    idle(); rs_used = 1'b1; rs_add = 5'd4;
    settle();
    chk("ovf_err", 32'(sb_err), 32'd1);
    chk("ovf_stall", 32'(stall), 32'd1);
    adv();
    for (int k = 0; k < 2; k++) begin
      idle(); wb_write_reg = 1'b1; wb_add = 5'd4; tick();
    end
    idle(); rs_used = 1'b1; rs_add = 5'd4;
    settle();
    chk("ovf_cnt1", 32'(stall), 32'd1);
    adv();
    idle(); wb_write_reg = 1'b1; wb_add = 5'd4; tick();
    idle(); rs_used = 1'b1; rs_add = 5'd4;
    settle();
    chk("ovf_cnt0", 32'(stall), 32'd0);
    adv();

    // underflow on r6
    idle(); reset = 1'b1; tick();
    idle();
    settle();
    chk("udf_pre", 32'(sb_err), 32'd0);
    adv();
    idle(); wb_write_reg = 1'b1; wb_add = 5'd6; tick();
    idle();
    settle();
    chk("udf_err", 32'(sb_err), 32'd1);
    adv();

    // reset while r2/r3 are pending
    idle(); issue_valid = 1'b1; issue_add = 5'd8; tick();
    idle(); wb_write_reg = 1'b1; wb_add = 5'd8; wb_data = 32'h77; tick();
    idle(); issue_valid = 1'b1; issue_add = 5'd2; tick();
    idle(); issue_valid = 1'b1; issue_add = 5'd3; tick();
    idle(); reset = 1'b1; tick();
    idle(); rs_used = 1'b1; rt_used = 1'b1;
    rs_add = 5'd2; rt_add = 5'd3;
    settle();
    chk("mid_stall", 32'(stall), 32'd0);
    adv();
    idle(); rs_add = 5'd8; rt_add = 5'd3;
    settle();
    chk("mid_r8", rs_data, 32'd0);
    chk("mid_err", 32'(sb_err), 32'd0);
    adv();

    // randomized traffic, mostly on a few registers
    for (int n = 0; n < 3000; n++) begin
      reset        = ($urandom_range(99) == 0);
      wb_write_reg = ($urandom_range(2) == 0);
      wb_data      = $urandom;
      wb_add       = 5'($urandom_range(($urandom_range(7) == 0) ? 31 : 7));
      rs_add       = 5'($urandom_range(7));
      rt_add       = 5'($urandom_range(($urandom_range(7) == 0) ? 31 : 7));
      rs_used      = $urandom_range(1) == 1;
      rt_used      = $urandom_range(1) == 1;
      issue_valid  = $urandom_range(1) == 1;
      issue_add    = 5'($urandom_range(7));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
